// File: rtl/gg_dram_pkg.sv
// Shared types and defaults for the FastRAM DRAM cycle scheduler.
// The optional statistics outputs of dram_cycle_scheduler are enabled by DRAM_SCHED_STATS_EN.
package gg_dram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REF_CAS,
        REF_RAS,
        ACC_ROW,
        ACC_COL,
        PRE
    } state_t;

    typedef struct packed {
        logic access_ras;
        logic access_ucas;
        logic access_lcas;
        logic refresh_ras;
        logic refresh_cas;
        logic col_sel;
        logic ack;
    } strobes_t;

    localparam int BACKLOG_W            = 3;
    localparam int DEF_REFRESH_INTERVAL = 108;
    localparam int DEF_MAX_BACKLOG      = 4;
    localparam int DEF_PRECHARGE_CYCLES = 1;

endpackage

// File: rtl/dram_cycle_scheduler_refresh_timer.sv
// Refresh interval counter and saturating backlog of pending CAS-before-RAS refreshes.
module refresh_timer
    import gg_dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_BACKLOG      = DEF_MAX_BACKLOG
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 done_ref,
    output logic                 tick,
    output logic [BACKLOG_W-1:0] backlog
);

    localparam int                   CNT_W  = $clog2(REFRESH_INTERVAL + 1);
    localparam logic [CNT_W-1:0]     RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [BACKLOG_W-1:0] BL_MAX = BACKLOG_W'(MAX_BACKLOG);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == '0);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt     <= RELOAD;
            backlog <= '0;
        end else begin
            cnt <= tick ? RELOAD : cnt - 1'b1;
            // A tick that finds the backlog saturated is dropped.
            if (tick && !done_ref && backlog != BL_MAX)
                backlog <= backlog + 1'b1;
            else if (!tick && done_ref && backlog != '0)
                backlog <= backlog - 1'b1;
        end
    end

endmodule

// File: rtl/dram_cycle_scheduler.sv
// Arbitrates Zorro bus accesses against periodic refresh and drives DRAM strobe intents.
// Optional statistics outputs (forced_cnt, max_backlog_seen) exist only with DRAM_SCHED_STATS_EN.
module dram_cycle_scheduler
    import gg_dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_BACKLOG      = DEF_MAX_BACKLOG,
    parameter int PRECHARGE_CYCLES = DEF_PRECHARGE_CYCLES
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic                 ASn,
    input  logic                 ram_sel,
    input  logic                 UDSn,
    input  logic                 LDSn,
    output logic                 access_ras,
    output logic                 access_ucas,
    output logic                 access_lcas,
    output logic                 refresh_ras,
    output logic                 refresh_cas,
    output logic                 col_sel,
    output logic                 ack,
    output logic [BACKLOG_W-1:0] backlog
`ifdef DRAM_SCHED_STATS_EN
    ,
    output logic [7:0]           forced_cnt,
    output logic [BACKLOG_W-1:0] max_backlog_seen
`endif
);

    localparam logic [BACKLOG_W-1:0] BL_MAX   = BACKLOG_W'(MAX_BACKLOG);
    localparam logic [1:0]           PRE_LOAD = 2'(PRECHARGE_CYCLES - 1);

    state_t   state, state_nxt;
    strobes_t str;
    logic     as_s, req, tick, done_ref, arb_en, forced_delay;
    logic [1:0] pre_cnt;

    assign req      = as_s & ram_sel;
    assign done_ref = (state == REF_RAS);
    // The last precharge cycle arbitrates like IDLE so a forced refresh costs 2 + PRECHARGE_CYCLES.
    assign arb_en   = (state == IDLE) || (state == PRE && pre_cnt == '0);
    assign forced_delay = arb_en && (backlog == BL_MAX) && req;

    refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .MAX_BACKLOG      (MAX_BACKLOG)
    ) u_refresh_timer (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .done_ref (done_ref),
        .tick     (tick),
        .backlog  (backlog)
    );

    function automatic state_t arbitrate(input logic [BACKLOG_W-1:0] bl, input logic rq,
                                         input logic as);
        if (bl == BL_MAX)               return REF_CAS;
        else if (rq)                    return ACC_ROW;
        else if (bl != '0 && !as)       return REF_CAS;
        else                            return IDLE;
    endfunction

    function automatic strobes_t strobes_for(input state_t s, input logic ucas, input logic lcas);
        strobes_t o;
        o = '0;
        case (s)
            REF_CAS: o.refresh_cas = 1'b1;
            REF_RAS: begin o.refresh_cas = 1'b1; o.refresh_ras = 1'b1; end
            ACC_ROW: o.access_ras = 1'b1;
            ACC_COL: begin
                o.access_ras  = 1'b1;
                o.col_sel     = 1'b1;
                o.access_ucas = ucas;
                o.access_lcas = lcas;
                o.ack         = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arbitrate(backlog, req, as_s);
            REF_CAS: state_nxt = REF_RAS;
            REF_RAS: state_nxt = PRE;
            ACC_ROW: state_nxt = as_s ? ACC_COL : PRE;
            ACC_COL: state_nxt = as_s ? ACC_COL : PRE;
            PRE:     state_nxt = (pre_cnt == '0) ? arbitrate(backlog, req, as_s) : PRE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            as_s    <= 1'b0;
            state   <= IDLE;
            str     <= '0;
            pre_cnt <= '0;
        end else begin
            as_s  <= !ASn;
            state <= state_nxt;
            str   <= strobes_for(state_nxt, !UDSn, !LDSn);
            if (state_nxt == PRE && state != PRE)
                pre_cnt <= PRE_LOAD;
            else if (state == PRE && pre_cnt != '0)
                pre_cnt <= pre_cnt - 1'b1;
        end
    end

    assign access_ras  = str.access_ras;
    assign access_ucas = str.access_ucas;
    assign access_lcas = str.access_lcas;
    assign refresh_ras = str.refresh_ras;
    assign refresh_cas = str.refresh_cas;
    assign col_sel     = str.col_sel;
    assign ack         = str.ack;

`ifdef DRAM_SCHED_STATS_EN
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            forced_cnt       <= '0;
            max_backlog_seen <= '0;
        end else begin
            if (forced_delay && forced_cnt != 8'hFF)
                forced_cnt <= forced_cnt + 1'b1;
            if (backlog > max_backlog_seen)
                max_backlog_seen <= backlog;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = forced_delay ^ tick;
`endif

endmodule

// File: tb/tb_dram_cycle_scheduler.sv
// Scoreboard bench for dram_cycle_scheduler: stimulus queues expected outputs per cycle, a monitor compares.
module tb_dram_cycle_scheduler;

    logic       CLK, RESETn, ASn, ram_sel, UDSn, LDSn;
    logic       access_ras, access_ucas, access_lcas, refresh_ras, refresh_cas, col_sel, ack;
    logic [2:0] backlog;
`ifdef DRAM_SCHED_STATS_EN
    logic [7:0] forced_cnt;
    logic [2:0] max_backlog_seen;
`endif

    dram_cycle_scheduler dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .ASn         (ASn),
        .ram_sel     (ram_sel),
        .UDSn        (UDSn),
        .LDSn        (LDSn),
        .access_ras  (access_ras),
        .access_ucas (access_ucas),
        .access_lcas (access_lcas),
        .refresh_ras (refresh_ras),
        .refresh_cas (refresh_cas),
        .col_sel     (col_sel),
        .ack         (ack),
        .backlog     (backlog)
`ifdef DRAM_SCHED_STATS_EN
        ,
        .forced_cnt       (forced_cnt),
        .max_backlog_seen (max_backlog_seen)
`endif
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [9:0] exp;
    } chk_t;

    chk_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Posedges since reset release; edge N is the Nth rising edge after RESETn goes high.
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [9:0] pk(input logic aras, input logic uc, input logic lc,
                                      input logic rras, input logic rcas, input logic col,
                                      input logic ak, input logic [2:0] bl);
        return {aras, uc, lc, rras, rcas, col, ak, bl};
    endfunction

    function automatic logic [9:0] full(input logic [2:0] bl);
        return pk(1, 1, 1, 0, 0, 1, 1, bl);
    endfunction

    task automatic push(input int c, input string n, input logic [9:0] e);
        chk_t ch;
        ch.cyc  = c;
        ch.name = n;
        ch.exp  = e;
        q.push_back(ch);
    endtask

    task automatic at_negedge(input int c);
        int n = 0;
        while (cyc != c) begin
            @(negedge CLK);
            n++;
            if (n > 5000) begin
                $display("FAIL wait_cycle: cycle %0d not reached, at %0d", c, cyc);
                $fatal(1, "cycle wait expired");
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() > 0) begin
            $display("FAIL drain: %0d checks never reached, next cycle %0d", q.size(), q[0].cyc);
            fails++;
            q.delete();
        end
    endtask

    // Monitor: compares outputs against every queued expectation whose cycle has come.
    initial begin
        chk_t       ch;
        logic [9:0] act;
        forever begin
            @(negedge CLK);
            act = {access_ras, access_ucas, access_lcas, refresh_ras, refresh_cas,
                   col_sel, ack, backlog};
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                ch = q.pop_front();
                tests++;
                if (ch.cyc != cyc) begin
                    $display("FAIL %s: check for cycle %0d missed, now %0d", ch.name, ch.cyc, cyc);
                    fails++;
                end else if (act !== ch.exp) begin
                    $display("FAIL %s @%0d: got ras,uc,lc,rras,rcas,col,ack,bl=%b required %b",
                             ch.name, cyc, act, ch.exp);
                    fails++;
                end
            end
        end
    end

    logic mx_ok;
    initial begin
        forever begin
            @(negedge CLK);
            mx_ok = !((access_ras | access_ucas | access_lcas) && (refresh_ras | refresh_cas));
            assert (mx_ok) else begin
                $display("FAIL mutex @%0d: access and refresh strobes both active", cyc);
                fails++;
            end
        end
    end

    initial begin
        RESETn  = 1'b0;
        ASn     = 1'b1;
        ram_sel = 1'b0;
        UDSn    = 1'b1;
        LDSn    = 1'b1;
        push(0, "reset", '0);
        repeat (3) @(negedge CLK);
        RESETn = 1'b1;

        // Idle refresh, read, byte write, abort.
        push(107, "idle_pre_tick", pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(108, "idle_tick",     pk(0, 0, 0, 0, 0, 0, 0, 3'd1));
        push(109, "ref_cas",       pk(0, 0, 0, 0, 1, 0, 0, 3'd1));
        push(110, "ref_ras",       pk(0, 0, 0, 1, 1, 0, 0, 3'd1));
        push(111, "ref_pre",       pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(112, "ref_idle",      pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(117, "rd_row",        pk(1, 0, 0, 0, 0, 0, 0, 3'd0));
        push(118, "rd_col",        full(3'd0));
        push(119, "rd_hold1",      full(3'd0));
        push(120, "rd_hold2",      full(3'd0));
        push(121, "rd_hold3",      full(3'd0));
        push(122, "rd_pre",        pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(123, "rd_idle",       pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(127, "wr_row",        pk(1, 0, 0, 0, 0, 0, 0, 3'd0));
        push(128, "wr_col",        pk(1, 1, 0, 0, 0, 1, 1, 3'd0));
        push(129, "wr_hold",       pk(1, 1, 0, 0, 0, 1, 1, 3'd0));
        push(131, "wr_hold_last",  pk(1, 1, 0, 0, 0, 1, 1, 3'd0));
        push(132, "wr_pre",        pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(137, "ab_row",        pk(1, 0, 0, 0, 0, 0, 0, 3'd0));
        push(138, "ab_pre",        pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(139, "ab_idle",       pk(0, 0, 0, 0, 0, 0, 0, 3'd0));
        push(147, "rs_row",        pk(1, 0, 0, 0, 0, 0, 0, 3'd0));
        push(148, "rs_col",        full(3'd0));

        at_negedge(115);
        ASn = 1'b0; ram_sel = 1'b1; UDSn = 1'b0; LDSn = 1'b0;
        at_negedge(120);
        ASn = 1'b1;
        at_negedge(125);
        ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b1;
        at_negedge(130);
        ASn = 1'b1;
        at_negedge(135);
        ASn = 1'b0; UDSn = 1'b0; LDSn = 1'b0;
        at_negedge(136);
        ASn = 1'b1;
        at_negedge(145);
        ASn = 1'b0;
        at_negedge(148);

        // Asynchronous reset in the middle of ACC_COL.
        @(posedge CLK);
        #1;
        RESETn  = 1'b0;
        ASn     = 1'b1;
        ram_sel = 1'b0;
        push(0, "rst_mid", '0);
        repeat (3) @(negedge CLK);

        // Saturation: one long access spans five refresh intervals.
        push(2,   "sat_row",    pk(1, 0, 0, 0, 0, 0, 0, 3'd0));
        push(3,   "sat_col",    full(3'd0));
        push(107, "sat_b0",     full(3'd0));
        push(108, "sat_b1",     full(3'd1));
        push(216, "sat_b2",     full(3'd2));
        push(324, "sat_b3",     full(3'd3));
        push(432, "sat_b4",     full(3'd4));
        push(539, "sat_b4_pre", full(3'd4));
        push(541, "sat_drop",   full(3'd4));
        push(547, "frc_pre",    pk(0, 0, 0, 0, 0, 0, 0, 3'd4));
        push(548, "frc_cas",    pk(0, 0, 0, 0, 1, 0, 0, 3'd4));
        push(549, "frc_ras",    pk(0, 0, 0, 1, 1, 0, 0, 3'd4));
        push(550, "frc_pre2",   pk(0, 0, 0, 0, 0, 0, 0, 3'd3));
        push(551, "frc_row",    pk(1, 0, 0, 0, 0, 0, 0, 3'd3));
        push(552, "frc_ack",    full(3'd3));
        push(557, "end_pre",    pk(0, 0, 0, 0, 0, 0, 0, 3'd3));
        push(558, "end_ref",    pk(0, 0, 0, 0, 1, 0, 0, 3'd3));
        ASn = 1'b0; ram_sel = 1'b1; UDSn = 1'b0; LDSn = 1'b0;
        RESETn = 1'b1;
        at_negedge(545);
        ASn = 1'b1;
        at_negedge(546);
        ASn = 1'b0;
        at_negedge(555);
        ASn = 1'b1;
        drain();

`ifdef DRAM_SCHED_STATS_EN
        tests++;
        if (forced_cnt !== 8'd1) begin
            $display("FAIL forced_cnt: got %0d required 1", forced_cnt);
            fails++;
        end
        tests++;
        if (max_backlog_seen !== 3'd4) begin
            $display("FAIL max_backlog_seen: got %0d required 4", max_backlog_seen);
            fails++;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
